// File: rtl/btn_pkg.sv
// Shared definitions for the button-handling blocks.
//   state_e              : click-decoder FSM state encoding
//   TICKS_PER_MS_DEFAULT : 1 us ticks per ms, the default for every tick consumer
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } state_e;

    localparam int unsigned TICKS_PER_MS_DEFAULT = 1000;

endpackage

// File: rtl/btn_click_decoder_if.sv
// Signal bundle between the button debouncer side and the click decoder.
//   i_tick_1us  : one-clk pulse every 1 us
//   i_btn_pulse : one-clk debounced press pulse
//   o_single    : one-clk pulse, single click resolved
//   o_double    : one-clk pulse, double click resolved
//   o_triple    : one-clk pulse, triple click resolved
//   o_busy      : high while a click group is open
// master drives the inputs and observes the events; slave is the decoder.
interface btn_click_decoder_if;

    logic i_tick_1us;
    logic i_btn_pulse;
    logic o_single;
    logic o_double;
    logic o_triple;
    logic o_busy;

    modport master (
        output i_tick_1us,
        output i_btn_pulse,
        input  o_single,
        input  o_double,
        input  o_triple,
        input  o_busy
    );

    modport slave (
        input  i_tick_1us,
        input  i_btn_pulse,
        output o_single,
        output o_double,
        output o_triple,
        output o_busy
    );

endinterface

// File: rtl/ms_window_timer.sv
// Click-grouping window timer: counts 1 us ticks into ms and flags the end of
// a DBL_WIN_MS window.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   i_tick_1us : 1 us tick
//   i_clear    : restart the window (counters to 0)
//   i_run      : counters advance only while high, otherwise held at 0
//   o_timeout  : combinational, high on the tick that completes the window
module ms_window_timer
    import btn_pkg::*;
#(
    parameter int unsigned DBL_WIN_MS   = 300,
    parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick_1us,
    input  logic i_clear,
    input  logic i_run,
    output logic o_timeout
);

    localparam int unsigned UW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned MW = ($clog2(DBL_WIN_MS + 1) > 0) ? $clog2(DBL_WIN_MS + 1) : 1;

    localparam logic [UW-1:0] US_LAST = UW'(TICKS_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST = MW'(DBL_WIN_MS - 1);

    logic [UW-1:0] r_us_cnt;
    logic [MW-1:0] r_ms_cnt;
    logic          w_ms_tick;

    assign w_ms_tick = i_run && i_tick_1us && (r_us_cnt == US_LAST);
    assign o_timeout = w_ms_tick && (r_ms_cnt == MS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_us_cnt <= '0;
            r_ms_cnt <= '0;
        end else if (!i_run || i_clear) begin
            // A clear outranks a coincident tick, so a press on the timeout
            // tick discards that tick and restarts the window.
            r_us_cnt <= '0;
            r_ms_cnt <= '0;
        end else if (i_tick_1us) begin
            if (w_ms_tick) begin
                r_us_cnt <= '0;
                r_ms_cnt <= (r_ms_cnt == MS_LAST) ? '0 : r_ms_cnt + MW'(1);
            end else begin
                r_us_cnt <= r_us_cnt + UW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_click_decoder.sv
// Groups debounced presses into single/double/triple click events. Each press
// restarts a DBL_WIN_MS window; a window expiry resolves the group, a third
// press resolves it immediately as a triple.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : btn_click_decoder_if.slave (tick/press in, event pulses and busy out)
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int unsigned DBL_WIN_MS   = 300,
    parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    btn_click_decoder_if.slave    bus
);

    state_e r_state;
    logic   r_single;
    logic   r_double;
    logic   r_triple;
    logic   r_busy;
    logic   w_timeout;
    logic   w_run;

    assign w_run = (r_state != ST_IDLE);

    ms_window_timer #(
        .DBL_WIN_MS   (DBL_WIN_MS),
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_tick_1us (bus.i_tick_1us),
        .i_clear    (bus.i_btn_pulse),
        .i_run      (w_run),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_triple <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_triple <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_btn_pulse) begin
                        r_state <= ST_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    // Press checked first: a press on the timeout tick stays in-window.
                    if (bus.i_btn_pulse) begin
                        r_state <= ST_TWO;
                    end else if (w_timeout) begin
                        r_state  <= ST_IDLE;
                        r_single <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (bus.i_btn_pulse) begin
                        r_state  <= ST_IDLE;
                        r_triple <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state  <= ST_IDLE;
                        r_double <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_single = r_single;
    assign bus.o_double = r_double;
    assign bus.o_triple = r_triple;
    assign bus.o_busy   = r_busy;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Directed bench for btn_click_decoder with a 3 ms x 4 tick (12 tick) window.
module tb_btn_click_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_single;
    int   n_double;
    int   n_triple;
    int   n_multi;

    btn_click_decoder_if bus ();

    btn_click_decoder #(
        .DBL_WIN_MS   (3),
        .TICKS_PER_MS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given one-cycle inputs; outputs sampled 1 ns after the edge.
    task automatic step(input logic tick, input logic press);
        bus.i_tick_1us  = tick;
        bus.i_btn_pulse = press;
        @(posedge clk);
        #1;
        bus.i_tick_1us  = 1'b0;
        bus.i_btn_pulse = 1'b0;
        n_single += int'(bus.o_single);
        n_double += int'(bus.o_double);
        n_triple += int'(bus.o_triple);
        if (int'(bus.o_single) + int'(bus.o_double) + int'(bus.o_triple) > 1) n_multi++;
    endtask

    // n ticks, each preceded by a quiet cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic clr_counts();
        n_single = 0;
        n_double = 0;
        n_triple = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_multi  = 0;
        clr_counts();
        bus.i_tick_1us  = 1'b0;
        bus.i_btn_pulse = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_single", int'(bus.o_single), 0);
        check("rst_double", int'(bus.o_double), 0);
        check("rst_triple", int'(bus.o_triple), 0);
        check("rst_busy",   int'(bus.o_busy),   0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: single click
        clr_counts();
        step(1'b0, 1'b1);
        check("s1_busy_rise", int'(bus.o_busy), 1);
        ticks(11);
        check("s1_no_early", n_single, 0);
        check("s1_busy_hold", int'(bus.o_busy), 1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s1_single", int'(bus.o_single), 1);
        check("s1_busy_fall", int'(bus.o_busy), 0);
        step(1'b0, 1'b0);
        check("s1_single_1cyc", int'(bus.o_single), 0);
        check("s1_count", n_single, 1);
        check("s1_others", n_double + n_triple, 0);

        // 2: double click, window counted from the second press
        clr_counts();
        step(1'b0, 1'b1);
        ticks(5);
        step(1'b0, 1'b1);
        ticks(11);
        check("s2_no_early", n_double + n_single, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s2_double", int'(bus.o_double), 1);
        check("s2_busy_fall", int'(bus.o_busy), 0);
        step(1'b0, 1'b0);
        check("s2_counts", n_single * 100 + n_double * 10 + n_triple, 10);

        // 3: triple click, no window wait
        clr_counts();
        step(1'b0, 1'b1);
        ticks(4);
        step(1'b0, 1'b1);
        ticks(4);
        check("s3_busy_pre", int'(bus.o_busy), 1);
        step(1'b0, 1'b1);
        check("s3_triple", int'(bus.o_triple), 1);
        check("s3_busy_fall", int'(bus.o_busy), 0);
        ticks(14);
        check("s3_counts", n_single * 100 + n_double * 10 + n_triple, 1);

        // 4: second press on the 12th tick wins over the timeout
        clr_counts();
        step(1'b0, 1'b1);
        ticks(11);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("s4_no_single", int'(bus.o_single), 0);
        check("s4_busy", int'(bus.o_busy), 1);
        ticks(11);
        check("s4_no_early", n_double + n_single, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s4_double", int'(bus.o_double), 1);
        step(1'b0, 1'b0);
        check("s4_counts", n_single * 100 + n_double * 10 + n_triple, 10);

        // 5: reset mid-group discards the group
        clr_counts();
        step(1'b0, 1'b1);
        ticks(6);
        #2;
        rst = 1'b0;
        #1;
        check("s5_rst_busy", int'(bus.o_busy), 0);
        check("s5_rst_events",
              int'(bus.o_single) + int'(bus.o_double) + int'(bus.o_triple), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        ticks(12);
        check("s5_no_event", n_single + n_double + n_triple, 0);
        step(1'b0, 1'b1);
        ticks(14);
        check("s5_counts", n_single * 100 + n_double * 10 + n_triple, 100);

        // 6: press in the cycle right after o_single
        clr_counts();
        step(1'b0, 1'b1);
        ticks(12);
        check("s6_first", int'(bus.o_single), 1);
        step(1'b0, 1'b1);
        check("s6_busy", int'(bus.o_busy), 1);
        ticks(11);
        check("s6_no_early", n_single, 1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s6_second", int'(bus.o_single), 1);
        step(1'b0, 1'b0);
        check("s6_counts", n_single * 100 + n_double * 10 + n_triple, 200);

        check("onehot_events", n_multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_click_decoder.md
# btn_click_decoder

Classifies debounced button presses into single-, double- and triple-click events. It sits directly downstream of the button debouncer and consumes two of its outputs:
- the one-cycle rising-edge press pulse;
- the 1 µs tick.

It emits one-cycle event pulses to the mode/control FSMs. Clicks are grouped by a millisecond window that restarts on every press.

## Interface
- `DBL_WIN_MS`, default 300: click-grouping window in ms, ≥1.
- `TICKS_PER_MS`, default 1000: `i_tick_1us` pulses per ms, ≥1 (reduced in simulation).

Ports:
- `clk`  in  1  system clock (100 MHz); single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `i_tick_1us`  in  1  one-`clk` pulse every 1 µs, from the debouncer.
- `i_btn_pulse`  in  1  one-`clk` press pulse, from the debouncer.
- `o_single`  out  1  one-`clk` pulse: single click resolved.
- `o_double`  out  1  one-`clk` pulse: double click resolved.
- `o_triple`  out  1  one-`clk` pulse: triple click resolved.
- `o_busy`  out  1  high while a click group is open (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: no click group open.
  - ONE: one press seen, window running.
  - TWO: two presses seen, window running.
- Transitions:
  - IDLE + press → ONE.
  - ONE + press → TWO.
  - ONE + timeout → IDLE, pulse `o_single`.
  - TWO + press → IDLE, pulse `o_triple`.
  - TWO + timeout → IDLE, pulse `o_double`.
- Every press clears both counters, so the window restarts.
- Window timebase:
  - `us_cnt` (width `$clog2(TICKS_PER_MS)`, min 1) counts `i_tick_1us`.
  - When `us_cnt` = `TICKS_PER_MS`-1 and a tick arrives: wrap `us_cnt` to 0 and raise internal `ms_tick`.
  - `ms_cnt` (width `$clog2(DBL_WIN_MS+1)`) increments on `ms_tick`.
  - Timeout = `ms_tick` while `ms_cnt` = `DBL_WIN_MS`-1.
  - Counters run only in ONE/TWO; they are held at 0 in IDLE.
- Timeout therefore occurs on exactly the (`DBL_WIN_MS` × `TICKS_PER_MS`)-th `i_tick_1us` after the most recent press.
- Boundary rules:
  - Press and timeout tick in the same cycle: the press wins. It is in-window, the tick is discarded and the counters clear.
  - Press and `i_tick_1us` in the same cycle in IDLE: the tick is ignored and the counters start from 0.
  - A press in the cycle right after `o_single`/`o_double`/`o_triple` starts a new group (IDLE → ONE).
  - At most one of the three event outputs is high in any cycle.
  - Reset asserted mid-group: the group is discarded, no event is emitted, state returns to IDLE.
  - `i_btn_pulse` held high for more than one cycle is treated as one press per cycle. This is legal but not expected from the debouncer.

## Timing
- Reset values: state IDLE, `us_cnt` 0, `ms_cnt` 0, `o_single`/`o_double`/`o_triple` 0, `o_busy` 0.
- All outputs are registered.
- An event sampled at `clk` edge k makes its output high from edge k to edge k+1, i.e. exactly one cycle.
- `o_busy` rises at the edge sampling the first press and falls at the edge that raises the event pulse.
- `o_triple` latency: one edge after the third press (no window wait).
- `o_single`/`o_double` latency: one edge after the timeout tick.

## Structure
- Shared package `btn_pkg` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_ONE`=2'd1, `ST_TWO`=2'd2;
  - the default `TICKS_PER_MS` (1000), used by other tick consumers.
- One natural sub-module is `ms_window_timer`, holding `us_cnt` and `ms_cnt`:
  - inputs: `clk`, `rst`, `i_tick_1us`, `clear`, `run`;
  - output: `o_timeout`.
- The FSM and output registers stay in `btn_click_decoder`.

## Test plan
All scenarios use `DBL_WIN_MS`=3, `TICKS_PER_MS`=4, so the window is 12 ticks.
1. One press, then 12 ticks → `o_single` high for 1 cycle, one edge after tick 12; `o_busy` high for that span; no other event.
2. Press, press after 5 ticks, then 12 ticks → `o_double` only, one edge after tick 12 counted from the second press.
3. Three presses 4 ticks apart → `o_triple` one edge after the third press; `o_busy` low on the same edge; no `o_single`/`o_double`.
4. Second press in the same cycle as the 12th tick → no `o_single`; state TWO; the window restarts and `o_double` follows 12 ticks later.
5. Reset asserted 6 ticks after a press → all outputs 0 immediately, state IDLE; after release, a press followed by 12 ticks gives exactly one `o_single`.
6. Back-to-back: a press in the cycle after `o_single` → `o_busy` high, and a new `o_single` 12 ticks later; two single events in total.
